// File: rtl/fillrect_pkg.sv
// Shared types for the rectangle filler and its colour generator.
package fillrect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        XSTRIPE = 2'd1,
        YSTRIPE = 2'd2,
        CHECKER = 2'd3
    } mode_t;

endpackage

// File: rtl/fill_colour_gen.sv
// Combinational pixel colour from pattern mode, base colour and pixel position.
module fill_colour_gen
    import fillrect_pkg::*;
#(
    parameter int XW        = 8,
    parameter int YW        = 7,
    parameter int CW        = 3,
    parameter int CHK_SHIFT = 3
) (
    input  mode_t         mode,
    input  logic [CW-1:0] colour,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic [CW-1:0] pix
);

    logic [XW-1:0] xs;
    logic [YW-1:0] ys;

    always_comb begin
        xs  = x >> CHK_SHIFT;
        ys  = y >> CHK_SHIFT;
        pix = colour;
        case (mode)
            SOLID:   pix = colour;
            XSTRIPE: pix = x[CW-1:0];
            YSTRIPE: pix = y[CW-1:0];
            CHECKER: pix = (xs[0] ^ ys[0]) ? ~colour : colour;
            default: pix = colour;
        endcase
    end

endmodule

// File: rtl/fillrect.sv
// Clipped rectangle filler: plots one pixel per clock, column-major, into the VGA plot port.
module fillrect
    import fillrect_pkg::*;
#(
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int CW        = 3,
    parameter int CHK_SHIFT = 3,
    localparam int XW       = $clog2(SCREEN_W),
    localparam int YW       = $clog2(SCREEN_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW:0]   w,
    input  logic [YW:0]   h,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] colour,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);

    localparam logic [XW+1:0] SW = (XW+2)'(SCREEN_W);
    localparam logic [YW+1:0] SH = (YW+2)'(SCREEN_H);

    state_t        state_q, state_d;
    logic [XW-1:0] px_q, px_d;
    logic [YW-1:0] py_q, py_d, y0_q, y0_d;
    logic [XW:0]   xe_q, xe_d;
    logic [YW:0]   ye_q, ye_d;
    mode_t         mode_q, mode_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] pix_q, pix_d, pix;
    logic          plot_q, plot_d, done_q, done_d;

    logic [XW+1:0] xsum;
    logic [YW+1:0] ysum;
    logic          empty, last_x, last_y;
    mode_t         gen_mode;
    logic [CW-1:0] gen_col;

    // Sums are two bits wider than the coordinates so an oversized w/h cannot wrap before clipping.
    assign xsum   = {2'b00, x0} + {1'b0, w};
    assign ysum   = {2'b00, y0} + {1'b0, h};
    assign empty  = (w == '0) | (h == '0) | ({2'b00, x0} >= SW) | ({2'b00, y0} >= SH);
    assign last_x = ({1'b0, px_q} + (XW+1)'(1)) == xe_q;
    assign last_y = ({1'b0, py_q} + (YW+1)'(1)) == ye_q;

    // The first pixel is coloured from the live inputs; later pixels from the latched copies.
    assign gen_mode = (state_q == IDLE) ? mode_t'(mode) : mode_q;
    assign gen_col  = (state_q == IDLE) ? colour : col_q;

    fill_colour_gen #(
        .XW        (XW),
        .YW        (YW),
        .CW        (CW),
        .CHK_SHIFT (CHK_SHIFT)
    ) u_colour (
        .mode   (gen_mode),
        .colour (gen_col),
        .x      (px_d),
        .y      (py_d),
        .pix    (pix)
    );

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        y0_d    = y0_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        mode_d  = mode_q;
        col_d   = col_q;
        plot_d  = plot_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    y0_d   = y0;
                    mode_d = mode_t'(mode);
                    col_d  = colour;
                    xe_d   = (xsum > SW) ? SW[XW:0] : xsum[XW:0];
                    ye_d   = (ysum > SH) ? SH[YW:0] : ysum[YW:0];
                    if (empty) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        plot_d  = 1'b0;
                    end else begin
                        state_d = FILL;
                        px_d    = x0;
                        py_d    = y0;
                        plot_d  = 1'b1;
                    end
                end
            end
            FILL: begin
                if (!last_y) begin
                    py_d = py_q + YW'(1);
                end else if (!last_x) begin
                    py_d = y0_q;
                    px_d = px_q + XW'(1);
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    plot_d  = 1'b0;
                    px_d    = '0;
                    py_d    = '0;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                plot_d  = 1'b0;
                done_d  = 1'b0;
                px_d    = '0;
                py_d    = '0;
            end
        endcase
        pix_d = plot_d ? pix : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            px_q    <= '0;
            py_q    <= '0;
            y0_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            mode_q  <= SOLID;
            col_q   <= '0;
            pix_q   <= '0;
            plot_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            y0_q    <= y0_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            mode_q  <= mode_d;
            col_q   <= col_d;
            pix_q   <= pix_d;
            plot_q  <= plot_d;
            done_q  <= done_d;
        end
    end

    assign vga_x      = px_q;
    assign vga_y      = py_q;
    assign vga_colour = pix_q;
    assign vga_plot   = plot_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fillrect.sv
// Randomised and directed bench for fillrect against a loop-based pixel-list model.
module tb_fillrect;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [8:0] w;
    logic [7:0] h;
    logic [1:0] mode;
    logic [2:0] colour;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int tests = 0;
    int fails = 0;

    fillrect dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .mode       (mode),
        .colour     (colour),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_colour(input int m, input int c, input int i, input int j);
        case (m)
            0:       return c;
            1:       return i % 8;
            2:       return j % 8;
            default: return (((i / 8) + (j / 8)) % 2 == 1) ? ((~c) & 7) : c;
        endcase
    endfunction

    function automatic int pack_pix();
        return (int'(vga_x) << 16) | (int'(vga_y) << 8) | int'(vga_colour);
    endfunction

    function automatic int pack_all();
        return int'({done, vga_plot, vga_x, vga_y, vga_colour});
    endfunction

    task automatic scramble();
        x0     = 8'($urandom);
        y0     = 7'($urandom);
        w      = 9'($urandom);
        h      = 8'($urandom);
        mode   = 2'($urandom);
        colour = 3'($urandom);
    endtask

    // Full start..done..release transaction, checking every plotted pixel in order.
    task automatic run_fill(input int xv, input int yv, input int wv, input int hv,
                            input int mv, input int cv, input int hold);
        int exp_q[$];
        int xe, ye, cnt, cyc;
        bit got_done;
        xe = (xv + wv < 160) ? xv + wv : 160;
        ye = (yv + hv < 120) ? yv + hv : 120;
        if (wv > 0 && hv > 0 && xv < 160 && yv < 120)
            for (int i = xv; i < xe; i++)
                for (int j = yv; j < ye; j++)
                    exp_q.push_back((i << 16) | (j << 8) | ref_colour(mv, cv, i, j));

        @(negedge clk);
        x0 = 8'(xv); y0 = 7'(yv); w = 9'(wv); h = 8'(hv); mode = 2'(mv); colour = 3'(cv);
        start = 1'b1;
        cnt = 0; cyc = 0; got_done = 1'b0;
        while (!got_done && cyc < exp_q.size() + 8) begin
            @(negedge clk);
            cyc++;
            if (vga_plot) begin
                if (cnt < exp_q.size()) check("pixel", pack_pix(), exp_q[cnt]);
                else check("extra_plot", pack_pix(), -1);
                cnt++;
            end
            if (done) got_done = 1'b1;
            scramble();
        end
        check("plot_count", cnt, exp_q.size());
        check("done_cycle", cyc, exp_q.size() + 1);
        check("done_outputs", pack_all(), 1 << 19);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("done_hold", pack_all(), 1 << 19);
        end
        start = 1'b0;
        @(negedge clk);
        check("done_drop", pack_all(), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; mode = '0; colour = '0;
        #12;
        check("reset_state", pack_all(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_fill(0, 0, 160, 120, 1, 0, 0);
        run_fill(150, 110, 20, 20, 0, 5, 1);
        run_fill(10, 10, 0, 5, 0, 2, 0);
        run_fill(200, 10, 5, 5, 0, 2, 0);
        run_fill(6, 6, 4, 4, 3, 3, 0);

        // Reset in the middle of a full-screen fill, then restart from scratch.
        @(negedge clk);
        x0 = 8'd0; y0 = 7'd0; w = 9'd160; h = 8'd120; mode = 2'd1; colour = 3'd0;
        start = 1'b1;
        repeat (60) @(negedge clk);
        check("mid_fill_plot", int'(vga_plot), 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", pack_all(), 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_fill(0, 0, 160, 120, 1, 0, 0);

        run_fill(20, 30, 7, 5, 2, 6, 5);
        run_fill(20, 30, 7, 5, 2, 6, 0);

        repeat (20) begin
            run_fill(int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 24)), int'($urandom_range(0, 24)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
